// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, wrap/saturate, event pulse and sticky overflow.
// Define UDC_CMP_EN to enable the registered compare-match pulse on cmp_match.
module updown_counter_mod #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf,
  output logic             cmp_match
);

  localparam logic [WIDTH:0] MAXW = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] STPW = STEP[WIDTH:0];
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] LIM  = MAXW + ONE;

  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   nxt_w;
  logic [WIDTH-1:0] nxt;
  logic             nevt;
  logic             unused_msb;

  assign cur        = {1'b0, count};
  assign up_sum     = cur + STPW;
  assign nxt        = nxt_w[WIDTH-1:0];
  assign unused_msb = nxt_w[WIDTH];

  // All arithmetic is WIDTH+1 bits so the wrap compare never sees a truncated sum.
  always_comb begin
    nxt_w = cur;
    nevt  = 1'b0;
    if (load) begin
      nxt_w = ({1'b0, load_val} > MAXW) ? MAXW : {1'b0, load_val};
    end else if (en) begin
      if (up) begin
        if (up_sum <= MAXW) begin
          nxt_w = up_sum;
        end else begin
          nevt  = 1'b1;
          nxt_w = sat ? MAXW : (up_sum - LIM);
        end
      end else begin
        if (cur >= STPW) begin
          nxt_w = cur - STPW;
        end else begin
          nevt  = 1'b1;
          nxt_w = sat ? '0 : (cur + LIM - STPW);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= nxt;
      evt   <= nevt;
      // a wrap on the same edge beats a clear request
      ovf   <= nevt | (ovf & ~clr_flag);
    end
  end

`ifdef UDC_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmp_match <= 1'b0;
    else     cmp_match <= (nxt == cmp_val) && (nxt != count);
  end
`else
  logic unused_cmp;
  assign cmp_match  = 1'b0;
  assign unused_cmp = ^cmp_val;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Randomised bench for updown_counter_mod: three configurations against an integer reference model.
module tb_updown_counter_mod;

`ifdef UDC_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_flag;
  logic [7:0] lv, cv;

  logic [3:0] c0, c1;
  logic [7:0] c2;
  logic [2:0] evt_o, ovf_o, cmp_o;

  int checks = 0;
  int errors = 0;

  int mx[3] = '{9, 9, 255};
  int st[3] = '{1, 3, 1};
  int mc[3];
  bit me[3], mo[3], mm[3];

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP(1)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(lv[3:0]),
    .clr_flag(clr_flag), .cmp_val(cv[3:0]), .count(c0), .evt(evt_o[0]), .ovf(ovf_o[0]),
    .cmp_match(cmp_o[0]));

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(lv[3:0]),
    .clr_flag(clr_flag), .cmp_val(cv[3:0]), .count(c1), .evt(evt_o[1]), .ovf(ovf_o[1]),
    .cmp_match(cmp_o[1]));

  updown_counter_mod #(.WIDTH(8)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(lv),
    .clr_flag(clr_flag), .cmp_val(cv), .count(c2), .evt(evt_o[2]), .ovf(ovf_o[2]),
    .cmp_match(cmp_o[2]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; me[i] = 0; mo[i] = 0; mm[i] = 0;
    end
  endtask

  // Reference: plain integer range arithmetic on 0..MAX, no bit widths involved.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int lvv, cvv, v, nc;
      bit e;
      lvv = (i == 2) ? int'(lv) : int'(lv[3:0]);
      cvv = (i == 2) ? int'(cv) : int'(cv[3:0]);
      nc = mc[i];
      e  = 0;
      if (load) begin
        nc = (lvv > mx[i]) ? mx[i] : lvv;
      end else if (en) begin
        v = up ? mc[i] + st[i] : mc[i] - st[i];
        if (v > mx[i]) begin
          e  = 1;
          nc = sat ? mx[i] : v % (mx[i] + 1);
        end else if (v < 0) begin
          e  = 1;
          nc = sat ? 0 : v + mx[i] + 1;
        end else begin
          nc = v;
        end
      end
      mm[i] = CMP_ON && (nc == cvv) && (nc != mc[i]);
      mo[i] = e || (mo[i] && !clr_flag);
      me[i] = e;
      mc[i] = nc;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cnt%0d", i), dut_cnt(i), mc[i]);
      chk($sformatf("evt%0d", i), int'(evt_o[i]), int'(me[i]));
      chk($sformatf("ovf%0d", i), int'(ovf_o[i]), int'(mo[i]));
      chk($sformatf("cmp%0d", i), int'(cmp_o[i]), int'(mm[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1; en = 0; up = 1; sat = 0; load = 0; clr_flag = 0; lv = 0; cv = 8'hff;
    model_reset();
    cyc(); cyc();
    chk("rst_cnt", int'(c0), 0);
    rst = 0;

    // count to 6, then reset between edges
    en = 1; up = 1; sat = 0;
    repeat (6) cyc();
    chk("pre_rst_cnt", int'(c0), 6);
    #3 rst = 1;
    #1;
    model_reset();
    chk("async_cnt", int'(c0), 0);
    chk("async_ovf", int'(ovf_o[0]), 0);
    compare_all();
    #1 rst = 0;
    cyc();
    chk("first_after_rst", int'(c0), 1);

    // decade wrap up
    repeat (8) cyc();
    chk("dec_9", int'(c0), 9);
    cyc();
    chk("dec_wrap_cnt", int'(c0), 0);
    chk("dec_wrap_evt", int'(evt_o[0]), 1);
    chk("dec_wrap_ovf", int'(ovf_o[0]), 1);
    cyc();
    chk("dec_evt_drop", int'(evt_o[0]), 0);

    // step-3 wrap down from 1
    load = 1; lv = 8'd1; cyc();
    load = 0; up = 0; cyc();
    chk("stp_wrap_cnt", int'(c1), 8);
    chk("stp_wrap_evt", int'(evt_o[1]), 1);
    cyc();
    chk("stp_next_cnt", int'(c1), 5);
    chk("stp_next_evt", int'(evt_o[1]), 0);

    // saturation at both limits
    sat = 1; up = 1; load = 1; lv = 8'd8; cyc();
    load = 0; cyc();
    chk("sat_9", int'(c0), 9);
    chk("sat_9_evt", int'(evt_o[0]), 0);
    repeat (2) begin
      cyc();
      chk("sat_hold_cnt", int'(c0), 9);
      chk("sat_hold_evt", int'(evt_o[0]), 1);
    end
    up = 0; load = 1; lv = 8'd0; cyc();
    load = 0; cyc();
    chk("sat_lo_cnt", int'(c0), 0);
    chk("sat_lo_evt", int'(evt_o[0]), 1);

    // load priority and clamp, then hold
    sat = 0; up = 1; load = 1; en = 1; lv = 8'd14; cyc();
    chk("clamp_cnt", int'(c0), 9);
    chk("clamp_evt", int'(evt_o[0]), 0);
    load = 0; en = 0;
    repeat (3) begin
      cyc();
      chk("hold_cnt", int'(c0), 9);
    end

    // clear vs. set race
    clr_flag = 1; cyc();
    chk("clr_ovf", int'(ovf_o[0]), 0);
    en = 1; cyc();
    chk("race_cnt", int'(c0), 0);
    chk("race_ovf", int'(ovf_o[0]), 1);
    en = 0; cyc();
    chk("clr2_ovf", int'(ovf_o[0]), 0);
    clr_flag = 0;

    // compare pulse
    cv = 8'd5; load = 1; lv = 8'd3; cyc();
    load = 0; en = 1; up = 1; cyc();
    chk("cmp_at4", int'(cmp_o[0]), 0);
    cyc();
    chk("cmp_cnt5", int'(c0), 5);
    chk("cmp_at5", int'(cmp_o[0]), int'(CMP_ON));
    en = 0; cyc();
    chk("cmp_hold5", int'(cmp_o[0]), 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      sat      = ($urandom_range(0, 3) == 0);
      load     = ($urandom_range(0, 15) == 0);
      clr_flag = ($urandom_range(0, 7) == 0);
      lv       = 8'($urandom);
      cv       = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1; cyc(); rst = 0;
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter. It replaces the fixed 3-bit up/down counter in the basic design set. Added over that counter:
- configurable width, modulus and step
- count enable and synchronous parallel load
- wrap or saturate mode
- registered wrap/limit event pulse and sticky overflow flag

Used as a general event/tick counter and as a BCD/modulo digit stage.

Parameters:
- WIDTH, 8: count register width in bits. Legal range is 2..32.
- MAX_VAL, 2**WIDTH-1: highest count value. Count range is 0..MAX_VAL. Legal range is 1..2**WIDTH-1.
- STEP, 1: increment/decrement amount per enabled cycle. Legal range is 1..MAX_VAL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = count up, 0 = count down.
- sat  in  1  limit mode: 1 = saturate at limits, 0 = modulo wrap.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- clr_flag  in  1  clears the sticky overflow flag.
- cmp_val  in  WIDTH  compare value; used only with the optional feature.
- count  out  WIDTH  current count (registered).
- evt  out  1  one-cycle pulse: a wrap or limit hit occurred on this update (registered).
- ovf  out  1  sticky overflow/underflow flag (registered).
- cmp_match  out  1  compare-match pulse (registered); optional feature.

Behaviour:
- Reset
  - Asynchronous: rst high immediately forces count=0, evt=0, ovf=0, cmp_match=0, regardless of clk.
  - Reset asserted mid-count aborts the operation. No partial update survives.
  - The first update occurs on the first rising clk edge after rst deasserts.
- Priority each rising edge: load > en > hold.
- Load
  - When load=1: count <= min(load_val, MAX_VAL), evt <= 0. ovf is unchanged apart from clr_flag.
- Count up (en=1, load=0, up=1)
  - If count+STEP <= MAX_VAL: count <= count+STEP, evt <= 0.
  - Otherwise, sat=0: count <= count+STEP-(MAX_VAL+1) (modulo wrap), evt <= 1, ovf <= 1.
  - Otherwise, sat=1: count <= MAX_VAL, evt <= 1, ovf <= 1.
  - sat=1 with count already at MAX_VAL still pulses evt each enabled cycle.
- Count down (en=1, load=0, up=0)
  - If count >= STEP: count <= count-STEP, evt <= 0.
  - Otherwise, sat=0: count <= count+(MAX_VAL+1)-STEP, evt <= 1, ovf <= 1.
  - Otherwise, sat=1: count <= 0, evt <= 1, ovf <= 1.
- Hold: en=0, load=0 -> count holds, evt <= 0.
- Arithmetic
  - Internal sums use WIDTH+1 bits; no intermediate truncation.
  - MAX_VAL=2**WIDTH-1, STEP=1 must give plain binary wrap.
- Timing
  - Latency is one cycle from input sample to count/evt.
  - evt is high in exactly the cycle where count shows the wrapped or limited value.
- ovf
  - Set on any evt-generating update.
  - clr_flag=1 clears ovf, but a set in the same cycle wins, so ovf stays 1.
- up, sat and STEP direction changes take effect on the same edge; there is no pipeline.

Optional Feature:
- Macro: UDC_CMP_EN
- Defined:
  - cmp_match <= 1 for one cycle when the next count value equals cmp_val and differs from the current count.
  - Applies to count and load updates alike.
  - Holding at a value, or saturating repeatedly, does not re-pulse.
  - Reset forces cmp_match to 0.
- Undefined:
  - cmp_match is tied to 0 and cmp_val is ignored.
  - The port list is unchanged in both builds.

Test Plan:
- Async reset: WIDTH=4, MAX_VAL=9, STEP=1; count to 6, assert rst between clk edges -> count=0 and ovf=0 immediately, before the next edge; first update after release gives count=1.
- Decade wrap up: up=1, sat=0, en=1 from 0 -> 1..9, then 0 with evt=1 and ovf=1 in that cycle; evt=0 on the next cycle.
- Step wrap down: MAX_VAL=9, STEP=3, start 1, up=0, sat=0 -> count=8, evt=1; then 5, evt=0.
- Saturation: MAX_VAL=9, sat=1, up=1 from 8 -> 9, then 9 with evt=1 on every enabled cycle; up=0 from 0 -> 0 with evt=1.
- Load priority/clamp: load=1, en=1, load_val=14 -> count=9, evt=0; load=0, en=0 -> holds 9 for 3 cycles.
- Flag race and compare (UDC_CMP_EN defined):
  - clr_flag=1 on the same edge as a wrap -> ovf stays 1; clr_flag alone next cycle -> ovf=0.
  - cmp_val=5 counting up from 3 -> cmp_match=1 only in the cycle count=5.
